// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-memory loader: FSM encoding, sync marker
// and length-header field layout.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_HI = 3'd1,
    ST_LEN_LO = 3'd2,
    ST_DATA   = 3'd3,
    ST_CKSUM  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int LEN_HI_CNT_MSB  = 3;
  localparam int LEN_HI_CNT_LSB  = 0;
  localparam int LEN_HI_RSVD_MSB = 7;
  localparam int LEN_HI_RSVD_LSB = 4;

  // Reserved upper nibble of the length-high byte must be zero.
  function automatic logic len_hi_valid(input logic [7:0] b);
    return (b[LEN_HI_RSVD_MSB:LEN_HI_RSVD_LSB] == 4'h0);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// master = host/memory side, slave = loader.
interface prog_loader_if #(parameter int ADDR_W = 12) ();
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic              mem_we;

  modport master (
    output in_data, in_valid, mem_busy,
    input  in_ready, mem_addr, mem_data, mem_we
  );

  modport slave (
    input  in_data, in_valid, mem_busy,
    output in_ready, mem_addr, mem_data, mem_we
  );
endinterface

// File: rtl/prog_loader_wr.sv
// Registered write stage: holds one pending byte until the memory is free,
// then strobes it and advances the address (saturating at the top of memory).
module prog_loader_wr #(
  parameter int ADDR_W = 12
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        push_data,
  input  logic              mem_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_we,
  output logic              pending
);

  logic              pend_r;
  logic [7:0]        data_r;
  logic [ADDR_W-1:0] addr_r;
  logic              write_s;

  // The strobe is gated by mem_busy so a write is never presented to a busy memory.
  assign write_s  = pend_r && !mem_busy;
  assign mem_we   = write_s;
  assign mem_addr = addr_r;
  assign mem_data = data_r;
  assign pending  = pend_r;

  // Pending byte register and write address.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_r <= 1'b0;
      data_r <= 8'h00;
      addr_r <= {ADDR_W{1'b0}};
    end else begin
      if (push) begin
        pend_r <= 1'b1;
        data_r <= push_data;
      end else if (write_s) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end

      if (clear) begin
        addr_r <= {ADDR_W{1'b0}};
      end else if (write_s && (addr_r != {ADDR_W{1'b1}})) begin
        addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        addr_r <= addr_r;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader for program memory; holds the CPU in reset while loading.
// Optional trailing checksum byte enabled by defining PROG_LOADER_CKSUM_EN.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int         ADDR_W    = 12,
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
  input  logic         clock,
  input  logic         reset,
  prog_loader_if.slave bus,
  output logic         cpu_hold,
  output logic         load_done,
  output logic         load_error
);

  state_e            state_r, next_state_s;
  logic              fire_s, in_ready_s, push_s, clear_s, last_s, wr_pend_s, is_sync_s;
  logic [3:0]        len_hi_r;
  logic [ADDR_W-1:0] len_r, count_r;
  logic              cpu_hold_s, load_done_s, load_error_s;
  logic              cpu_hold_r, load_done_r, load_error_r;
`ifdef PROG_LOADER_CKSUM_EN
  logic [7:0]        cksum_r;
`endif

  // Back-pressure only while a data byte is still waiting for the memory.
  assign in_ready_s   = !((state_r == ST_DATA) && (bus.mem_busy || wr_pend_s));
  assign bus.in_ready = in_ready_s;
  assign fire_s       = bus.in_valid && in_ready_s;
  assign is_sync_s    = (bus.in_data == SYNC_BYTE);
  assign last_s       = (count_r == len_r);
  assign push_s       = fire_s && (state_r == ST_DATA);
  assign clear_s      = fire_s && (state_r == ST_LEN_LO);

  assign cpu_hold   = cpu_hold_r;
  assign load_done  = load_done_r;
  assign load_error = load_error_r;

  prog_loader_wr #(.ADDR_W(ADDR_W)) u_wr (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear_s),
    .push      (push_s),
    .push_data (bus.in_data),
    .mem_busy  (bus.mem_busy),
    .mem_addr  (bus.mem_addr),
    .mem_data  (bus.mem_data),
    .mem_we    (bus.mem_we),
    .pending   (wr_pend_s)
  );

  // State register and registered status outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      cpu_hold_r   <= 1'b0;
      load_done_r  <= 1'b0;
      load_error_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      cpu_hold_r   <= cpu_hold_s;
      load_done_r  <= load_done_s;
      load_error_r <= load_error_s;
    end
  end

  // Next-state logic; DONE handles an incoming byte exactly like IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (fire_s && is_sync_s) next_state_s = ST_LEN_HI;
        else                     next_state_s = ST_IDLE;
      end
      ST_LEN_HI: begin
        if (fire_s) next_state_s = len_hi_valid(bus.in_data) ? ST_LEN_LO : ST_ERROR;
        else        next_state_s = ST_LEN_HI;
      end
      ST_LEN_LO: begin
        if (fire_s) next_state_s = ST_DATA;
        else        next_state_s = ST_LEN_LO;
      end
      ST_DATA: begin
        if (push_s && last_s) begin
`ifdef PROG_LOADER_CKSUM_EN
          next_state_s = ST_CKSUM;
`else
          next_state_s = ST_DONE;
`endif
        end else begin
          next_state_s = ST_DATA;
        end
      end
`ifdef PROG_LOADER_CKSUM_EN
      ST_CKSUM: begin
        if (fire_s) next_state_s = (bus.in_data == cksum_r) ? ST_DONE : ST_ERROR;
        else        next_state_s = ST_CKSUM;
      end
`endif
      ST_ERROR: begin
        if (fire_s && is_sync_s) next_state_s = ST_LEN_HI;
        else                     next_state_s = ST_ERROR;
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Status outputs follow the state being entered, so they line up with it.
  always_comb begin
    cpu_hold_s   = 1'b0;
    load_done_s  = 1'b0;
    load_error_s = 1'b0;
    case (next_state_s)
      ST_LEN_HI, ST_LEN_LO, ST_DATA, ST_CKSUM: cpu_hold_s = 1'b1;
      ST_DONE:  load_done_s = 1'b1;
      ST_ERROR: begin
        cpu_hold_s   = 1'b1;
        load_error_s = 1'b1;
      end
      default: cpu_hold_s = 1'b0;
    endcase
  end

  // Length latch and data byte counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi_r <= 4'h0;
      len_r    <= {ADDR_W{1'b0}};
      count_r  <= {ADDR_W{1'b0}};
    end else begin
      if (fire_s && (state_r == ST_LEN_HI)) begin
        len_hi_r <= bus.in_data[LEN_HI_CNT_MSB:LEN_HI_CNT_LSB];
      end else begin
        len_hi_r <= len_hi_r;
      end

      if (clear_s) begin
        len_r   <= ADDR_W'({len_hi_r, bus.in_data});
        count_r <= {ADDR_W{1'b0}};
      end else if (push_s && !last_s) begin
        len_r   <= len_r;
        count_r <= count_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        len_r   <= len_r;
        count_r <= count_r;
      end
    end
  end

`ifdef PROG_LOADER_CKSUM_EN
  // Running 8-bit sum of the data bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      cksum_r <= 8'h00;
    end else if (clear_s) begin
      cksum_r <= 8'h00;
    end else if (push_s) begin
      cksum_r <= cksum_r + bus.in_data;
    end else begin
      cksum_r <= cksum_r;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed frames plus randomized frames,
// compared against a frame-parsing reference model.
module tb_prog_loader;

  logic clock = 1'b0;
  logic reset;
  logic cpu_hold, load_done, load_error;

  always #5 clock = ~clock;

  prog_loader_if #(.ADDR_W(12)) bus ();

  prog_loader dut (
    .clock      (clock),
    .reset      (reset),
    .bus        (bus),
    .cpu_hold   (cpu_hold),
    .load_done  (load_done),
    .load_error (load_error)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int busy_pct = 0;
  int busy_req = 0;
  int done_cnt = 0;
  int we_busy_viol = 0;
  int cmp_idx = 0;

  logic [19:0] got_q[$];
  logic [19:0] exp_q[$];
  bit mdl_err  = 1'b0;
  bit mdl_hold = 1'b0;
  int mdl_done = 0;

  // write monitor, sampled mid-cycle
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) got_q.push_back({bus.mem_addr, bus.mem_data});
    if (bus.mem_we === 1'b1 && bus.mem_busy === 1'b1) we_busy_viol++;
    if (load_done === 1'b1) done_cnt++;
  end

  // memory busy generator: random, or a 3-cycle burst on request
  initial begin
    int last_req;
    int hold_left;
    last_req = 0;
    hold_left = 0;
    bus.mem_busy = 1'b0;
    forever begin
      @(posedge clock);
      #2;
      if (busy_req != last_req) begin
        last_req = busy_req;
        hold_left = 3;
      end
      if (hold_left > 0) begin
        bus.mem_busy = 1'b1;
        hold_left--;
      end else begin
        bus.mem_busy = ($urandom_range(0, 99) < busy_pct);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: walk the stream by frame rules, producing expected writes and status.
  task automatic model_stream(input logic [7:0] s[$]);
    int i, n;
    logic [7:0] sum;
    i = 0;
    while (i < s.size()) begin
      if (s[i] != 8'hA5) begin
        i++;
        continue;
      end
      mdl_err = 1'b0;
      mdl_hold = 1'b1;
      if (i + 2 >= s.size()) begin
        if (i + 1 < s.size() && s[i+1][7:4] != 4'h0) mdl_err = 1'b1;
        break;
      end
      if (s[i+1][7:4] != 4'h0) begin
        mdl_err = 1'b1;
        i += 2;
        continue;
      end
      n = int'(s[i+1][3:0]) * 256 + int'(s[i+2]) + 1;
      sum = 8'h00;
      for (int k = 0; k < n; k++) begin
        exp_q.push_back({12'(k), s[i+3+k]});
        sum = sum + s[i+3+k];
      end
      i += 3 + n;
`ifdef PROG_LOADER_CKSUM_EN
      if (s[i] != sum) begin
        mdl_err = 1'b1;
        i++;
        continue;
      end
      i++;
`endif
      mdl_hold = 1'b0;
      mdl_done++;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int w;
    w = 0;
    @(posedge clock);
    #1;
    bus.in_data = b;
    bus.in_valid = 1'b1;
    @(negedge clock);
    while (bus.in_ready !== 1'b1 && w < 200) begin
      w++;
      @(negedge clock);
    end
    if (w >= 200) chk("accept_timeout", 32'(w), 32'd0);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic settle_check(input string tag);
    int saved;
    saved = busy_pct;
    busy_pct = 0;
    repeat (6) @(posedge clock);
    @(negedge clock);
    chk({tag, "_nwr"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = cmp_idx; k < exp_q.size() && k < got_q.size(); k++)
      chk({tag, "_wr"}, 32'(got_q[k]), 32'(exp_q[k]));
    cmp_idx = exp_q.size();
    chk({tag, "_done"}, 32'(done_cnt), 32'(mdl_done));
    chk({tag, "_err"}, 32'(load_error), 32'(mdl_err));
    chk({tag, "_hold"}, 32'(cpu_hold), 32'(mdl_hold));
    busy_pct = saved;
  endtask

  task automatic run_stream(input string tag, input logic [7:0] s[$]);
    model_stream(s);
    foreach (s[i]) send_byte(s[i]);
    settle_check(tag);
  endtask

  task automatic make_frame(input int n, input bit bad_ck, output logic [7:0] f[$]);
    logic [7:0] sum, b;
    logic [11:0] m;
    f = {};
    m = 12'(n - 1);
    sum = 8'h00;
    f.push_back(8'hA5);
    f.push_back({4'h0, m[11:8]});
    f.push_back(m[7:0]);
    for (int k = 0; k < n; k++) begin
      b = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom_range(0, 255));
      f.push_back(b);
      sum = sum + b;
    end
`ifdef PROG_LOADER_CKSUM_EN
    f.push_back(bad_ck ? sum + 8'h01 : sum);
`else
    if (bad_ck) sum = 8'h00;
`endif
  endtask

  initial begin
    logic [7:0] f[$];
    logic [7:0] g[$];

    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_mem_data", 32'(bus.mem_data), 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    chk("rst_load_done", 32'(load_done), 32'd0);
    chk("rst_load_error", 32'(load_error), 32'd0);

    // basic 3-byte frame, cpu_hold rises right after the sync byte
`ifdef PROG_LOADER_CKSUM_EN
    f = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h66};
`else
    f = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
`endif
    model_stream(f);
    send_byte(f[0]);
    @(negedge clock);
    chk("hold_after_sync", 32'(cpu_hold), 32'd1);
    for (int i = 1; i < f.size(); i++) send_byte(f[i]);
    settle_check("basic");

    // leading garbage is discarded
    make_frame(5, 1'b0, g);
    f = '{8'h3C, 8'h7F};
    foreach (g[i]) f.push_back(g[i]);
    run_stream("garbage", f);

    // bad length header, then recovery
    f = '{8'hA5, 8'h10};
    run_stream("lenerr", f);
`ifdef PROG_LOADER_CKSUM_EN
    f = '{8'hA5, 8'h00, 8'h00, 8'h44, 8'h44};
`else
    f = '{8'hA5, 8'h00, 8'h00, 8'h44};
`endif
    run_stream("recover", f);

`ifdef PROG_LOADER_CKSUM_EN
    f = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h00};
    run_stream("ckerr", f);
    make_frame(3, 1'b0, f);
    run_stream("ck_recover", f);
`endif

    // memory busy burst during the second data byte
    make_frame(4, 1'b0, f);
    model_stream(f);
    for (int i = 0; i < 4; i++) send_byte(f[i]);
    busy_req++;
    @(negedge clock);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    chk("busy_mem_we", 32'(bus.mem_we), 32'd0);
    for (int i = 4; i < f.size(); i++) send_byte(f[i]);
    settle_check("busy");

    // randomized frames with random back-pressure and occasional bad checksum
    busy_pct = 30;
    for (int r = 0; r < 6; r++) begin
      make_frame($urandom_range(1, 40), ($urandom_range(0, 3) == 0), g);
      f = {};
      repeat ($urandom_range(0, 3)) f.push_back(8'($urandom_range(0, 127)));
      foreach (g[i]) f.push_back(g[i]);
      run_stream("rand", f);
    end
    busy_pct = 0;

    // reset in the middle of a 5-byte frame
    f = '{8'hA5, 8'h00, 8'h04, 8'h5A, 8'hC3};
    exp_q.push_back({12'h000, 8'h5A});
    exp_q.push_back({12'h001, 8'hC3});
    foreach (f[i]) send_byte(f[i]);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    chk("abort_hold", 32'(cpu_hold), 32'd0);
    chk("abort_we", 32'(bus.mem_we), 32'd0);
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    mdl_hold = 1'b0;
    mdl_err = 1'b0;
    settle_check("abort");

    // full-size image
    busy_pct = 10;
    make_frame(4096, 1'b0, f);
    run_stream("full", f);
    chk("full_last_addr", 32'(got_q[got_q.size()-1][19:8]), 32'h0FFF);

    chk("we_while_busy", 32'(we_busy_viol), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-stream writer for the 12-bit-addressed, 8-bit-wide program memory that the processor fetches from.
- Receives a framed image on a valid/ready byte interface and writes it sequentially from address 0.
- Holds the processor in reset (cpu_hold) while loading, then releases it.
- Sits between a host byte source (UART RX or test harness) and the program-memory write port.

Parameters:
- ADDR_W, 12, program-memory address width; image length up to 2**ADDR_W bytes.
- SYNC_BYTE, 8'hA5, frame start marker.

Ports:
- clock  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  8  incoming stream byte.
- in_valid  input  1  in_data valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- mem_busy  input  1  memory cannot take a write this cycle.
- mem_addr  output  ADDR_W  write address.
- mem_data  output  8  write data.
- mem_we  output  1  write strobe, one cycle per byte.
- cpu_hold  output  1  drives the processor reset input; high keeps it in reset.
- load_done  output  1  one-cycle pulse when an image is completed successfully.
- load_error  output  1  level; set on a framing or checksum error.

Behaviour:
- Reset values: state IDLE, in_ready 1, mem_addr 0, mem_data 0, mem_we 0, cpu_hold 0, load_done 0, load_error 0, byte counter 0, checksum 0.
- Reset mid-load: abandons the frame and returns to IDLE with cpu_hold 0. Memory contents are then undefined.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, then N data bytes, then CKSUM (CKSUM only when the feature is enabled).
  - LEN_HI[3:0] = (N-1)[11:8]; LEN_HI[7:4] must be 0.
  - LEN_LO = (N-1)[7:0].
  - N ranges 1..4096.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CKSUM, DONE, ERROR.
  - IDLE: accepted byte == SYNC_BYTE -> LEN_HI, cpu_hold<=1, load_error<=0. Any other byte is discarded.
  - LEN_HI: LEN_HI[7:4]!=0 -> ERROR. Otherwise latch the count high nibble -> LEN_LO.
  - LEN_LO: latch the count low byte, mem_addr<=0, checksum<=0 -> DATA.
  - DATA: each accepted byte registers mem_data<=byte and asserts mem_we for the next cycle (1-cycle latency), then checksum+=byte (mod 256).
    - mem_addr increments after each write, with no wrap within a frame.
    - After byte N (counter == latched N-1): feature on -> CKSUM; feature off -> DONE.
  - DONE: cpu_hold<=0, load_done pulses for 1 cycle, then -> IDLE.
  - ERROR: load_error=1, cpu_hold stays 1. An accepted SYNC_BYTE restarts the frame (-> LEN_HI, load_error<=0); other bytes are discarded.
- in_ready = 0 in DATA while mem_busy=1 or mem_we=1 (back-pressure). Otherwise in_ready = 1 in every state, including the DONE cycle; a byte accepted in DONE is processed as in IDLE.
- A SYNC_BYTE value inside LEN/DATA/CKSUM is treated as ordinary data, not a restart.
- mem_we is never asserted while mem_busy=1; the registered write waits until mem_busy=0.

Optional Feature:
- Macro: PROG_LOADER_CKSUM_EN.
- Defined: after the data bytes, a CKSUM byte is expected.
  - Equal to the 8-bit sum of the data bytes -> DONE.
  - Not equal -> ERROR.
- Undefined: no CKSUM state or checksum register; DATA goes directly to DONE.

Decomposition:
- Shared package holds:
  - FSM state encoding (3-bit, named states).
  - SYNC_BYTE default.
  - Length-header field positions.
- One sub-module is natural: prog_loader_wr, the registered write stage. It owns mem_addr/mem_data/mem_we, the address increment and the mem_busy hold.
- The FSM, counter and checksum stay in the top level.

Test Plan:
- Reset, then frame A5 00 02 11 22 33 (+CKSUM 66 with feature) -> writes 0:11, 1:22, 2:33. cpu_hold is high from the cycle after A5 until DONE. load_done pulses once.
- Bytes 3C 7F before A5 -> ignored, no mem_we. A following valid frame loads normally.
- LEN_HI = 10 -> ERROR, load_error=1, cpu_hold=1. A new A5 00 00 44 (+44) -> load_error clears, writes 0:44, done.
- Feature on, frame A5 00 01 01 02 with CKSUM 00 (expected 03) -> both bytes written, then ERROR, load_error=1, cpu_hold stays 1.
- mem_busy held high for 3 cycles during the second data byte -> in_ready low, write delayed, no byte lost, addresses consecutive.
- reset asserted after 2 of 5 data bytes -> next cycle IDLE, cpu_hold 0, mem_we 0. Fresh frame A5 0F FF + 4096 bytes -> last write at address FFF, done.
